// File: rtl/eight_bit_sequential_divider_if.sv
// rtl/eight_bit_sequential_divider_if.sv - request/result bundle for the sequential divider
interface eight_bit_sequential_divider_if;
  logic        start;
  logic [15:0] in1;
  logic [7:0]  in2;
  logic        busy;
  logic        done;
  logic [7:0]  quot;
  logic [7:0]  rem;
  logic        ovf;
  logic        div0;

  modport master (
    output start, in1, in2,
    input  busy, done, quot, rem, ovf, div0
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, quot, rem, ovf, div0
  );
endinterface

// File: rtl/eight_bit_sequential_divider.sv
// rtl/eight_bit_sequential_divider.sv - 16/8 restoring divider, IDLE/CALC/DONE FSM
// Optional macro DIV_APPROX_EN skips the APPROX_BITS low quotient bits and zeroes rem.
module eight_bit_sequential_divider #(
  parameter int APPROX_BITS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  eight_bit_sequential_divider_if.slave  bus
);

  if (APPROX_BITS < 1 || APPROX_BITS > 7) begin : g_bad_approx
    $error("APPROX_BITS must be in 1..7");
  end

`ifdef DIV_APPROX_EN
  localparam int ITERS = 8 - APPROX_BITS;
`else
  localparam int ITERS = 8;
`endif
  localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] pr_q;
  logic [7:0] dvd_q;
  logic [7:0] dsr_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] quot_q;
  logic [7:0] rem_q;
  logic       ovf_q;
  logic       div0_q;

  logic [8:0] shifted;
  logic       qbit;
  logic [7:0] pr_d;
  logic [7:0] dvd_d;
  logic [7:0] quot_d;
  logic [7:0] rem_d;

  // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
  always_comb begin
    shifted = {pr_q, dvd_q[7]};
    qbit    = (shifted >= {1'b0, dsr_q});
    pr_d    = qbit ? 8'(shifted - {1'b0, dsr_q}) : shifted[7:0];
    dvd_d   = {dvd_q[6:0], qbit};
`ifdef DIV_APPROX_EN
    quot_d  = dvd_d << APPROX_BITS;
    rem_d   = 8'h00;
`else
    quot_d  = dvd_d;
    rem_d   = pr_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pr_q    <= 8'h00;
      dvd_q   <= 8'h00;
      dsr_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= 8'h00;
      rem_q   <= 8'h00;
      ovf_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dsr_q  <= bus.in2;
            pr_q   <= bus.in1[15:8];
            dvd_q  <= bus.in1[7:0];
            cnt_q  <= 4'd0;
            busy_q <= 1'b1;
            // quotient cannot fit 8 bits when the high dividend byte reaches the divisor
            if (bus.in1[15:8] >= bus.in2) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quot_q  <= 8'hFF;
              rem_q   <= 8'hFF;
              ovf_q   <= 1'b1;
              div0_q  <= (bus.in2 == 8'h00);
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ovf_q   <= 1'b0;
            div0_q  <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.quot = quot_q;
  assign bus.rem  = rem_q;
  assign bus.ovf  = ovf_q;
  assign bus.div0 = div0_q;

endmodule
